// File: rtl/seg_scan_capture.sv
// Captures the digits of a 4-digit multiplexed 7-segment display by watching its
// anode and segment lines, decoding each stable digit to a hex value.
module seg_scan_capture #(
    parameter int SETTLE         = 4,
    parameter bit SEG_ACTIVE_LOW = 1'b1
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       A,
    input  logic       B,
    input  logic       C,
    input  logic       D,
    input  logic       E,
    input  logic       F,
    input  logic       G,
    input  logic       An0,
    input  logic       An1,
    input  logic       An2,
    input  logic       An3,
    input  logic       err_clr,
    output logic [6:0] seg0,
    output logic [6:0] seg1,
    output logic [6:0] seg2,
    output logic [6:0] seg3,
    output logic [3:0] hex0,
    output logic [3:0] hex1,
    output logic [3:0] hex2,
    output logic [3:0] hex3,
    output logic       valid0,
    output logic       valid1,
    output logic       valid2,
    output logic       valid3,
    output logic       frame_done,
    output logic       anode_err
);

    localparam logic [1:0] ST_WAIT   = 2'd0;
    localparam logic [1:0] ST_SETTLE = 2'd1;
    localparam logic [1:0] ST_HOLD   = 2'd2;

    localparam logic [3:0] SETTLE_C = SETTLE[3:0];

    // Returns {valid, hex} for a logical ABCDEFG pattern (bit6 = A).
    function automatic logic [4:0] decode7(input logic [6:0] p);
        logic [4:0] r;
        case (p)
            7'h7E:   r = {1'b1, 4'h0};
            7'h30:   r = {1'b1, 4'h1};
            7'h6D:   r = {1'b1, 4'h2};
            7'h79:   r = {1'b1, 4'h3};
            7'h33:   r = {1'b1, 4'h4};
            7'h5B:   r = {1'b1, 4'h5};
            7'h5F:   r = {1'b1, 4'h6};
            7'h70:   r = {1'b1, 4'h7};
            7'h7F:   r = {1'b1, 4'h8};
            7'h7B:   r = {1'b1, 4'h9};
            7'h77:   r = {1'b1, 4'hA};
            7'h1F:   r = {1'b1, 4'hB};
            7'h4E:   r = {1'b1, 4'hC};
            7'h3D:   r = {1'b1, 4'hD};
            7'h4F:   r = {1'b1, 4'hE};
            7'h47:   r = {1'b1, 4'hF};
            default: r = 5'b0_0000;
        endcase
        return r;
    endfunction

    logic [6:0] raw_seg;
    logic [6:0] norm_seg;
    logic [6:0] r_seg;
    logic [6:0] prev_seg;
    logic [3:0] r_an;
    logic [3:0] prev_an;

    logic [1:0] state;
    logic [1:0] state_nxt;
    logic [3:0] cnt;
    logic [3:0] cnt_nxt;
    logic [1:0] cur;
    logic [1:0] cur_nxt;
    logic [3:0] mask;
    logic [3:0] mask_set;
    logic       capture;
    logic       do_scan;

    logic       an_one;
    logic       an_multi;
    logic [1:0] an_idx;

    logic [6:0] seg_q   [4];
    logic [3:0] hex_q   [4];
    logic       valid_q [4];
    logic [4:0] dec;

    assign raw_seg  = {A, B, C, D, E, F, G};
    assign norm_seg = SEG_ACTIVE_LOW ? ~raw_seg : raw_seg;
    assign dec      = decode7(r_seg);
    assign mask_set = mask | (4'b0001 << cur_nxt);

    // Stage boundary: input registers plus a one-cycle history for change detection
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_seg    <= 7'h00;
            r_an     <= 4'b1111;
            prev_seg <= 7'h00;
            prev_an  <= 4'b1111;
        end else begin
            r_seg    <= norm_seg;
            r_an     <= {An3, An2, An1, An0};
            prev_seg <= r_seg;
            prev_an  <= r_an;
        end
    end

    always_comb begin
        an_one   = 1'b0;
        an_multi = 1'b0;
        an_idx   = 2'd0;
        case (r_an)
            4'b1110: begin an_one = 1'b1; an_idx = 2'd0; end
            4'b1101: begin an_one = 1'b1; an_idx = 2'd1; end
            4'b1011: begin an_one = 1'b1; an_idx = 2'd2; end
            4'b0111: begin an_one = 1'b1; an_idx = 2'd3; end
            4'b1111: ;
            default: an_multi = 1'b1;
        endcase
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        cur_nxt   = cur;
        capture   = 1'b0;
        do_scan   = 1'b0;
        case (state)
            ST_SETTLE: begin
                if (!an_one) begin
                    state_nxt = ST_WAIT;
                    cnt_nxt   = 4'd0;
                end else if (an_idx != cur) begin
                    cur_nxt = an_idx;
                    cnt_nxt = 4'd1;
                end else if (r_seg != prev_seg) begin
                    cnt_nxt = 4'd1;
                end else if (cnt < SETTLE_C) begin
                    cnt_nxt = cnt + 4'd1;
                end
            end
            ST_HOLD: do_scan = (r_an != prev_an);
            default: do_scan = 1'b1;
        endcase
        if (do_scan) begin
            if (an_one) begin
                state_nxt = ST_SETTLE;
                cur_nxt   = an_idx;
                cnt_nxt   = 4'd1;
            end else begin
                state_nxt = ST_WAIT;
                cnt_nxt   = 4'd0;
            end
        end
        // The capture fires on the edge the count reaches SETTLE, so SETTLE=1 captures on entry.
        if (state_nxt == ST_SETTLE && cnt_nxt == SETTLE_C) begin
            capture   = 1'b1;
            state_nxt = ST_HOLD;
        end
    end

    // Stage boundary: FSM, per-digit capture registers, frame mask and error flag
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state      <= ST_WAIT;
            cnt        <= 4'd0;
            cur        <= 2'd0;
            mask       <= 4'b0000;
            frame_done <= 1'b0;
            anode_err  <= 1'b0;
            for (int i = 0; i < 4; i++) begin
                seg_q[i]   <= 7'h00;
                hex_q[i]   <= 4'h0;
                valid_q[i] <= 1'b0;
            end
        end else begin
            state      <= state_nxt;
            cnt        <= cnt_nxt;
            cur        <= cur_nxt;
            frame_done <= 1'b0;
            if (capture) begin
                seg_q[cur_nxt]   <= r_seg;
                hex_q[cur_nxt]   <= dec[3:0];
                valid_q[cur_nxt] <= dec[4];
                if (mask_set == 4'b1111) begin
                    mask       <= 4'b0000;
                    frame_done <= 1'b1;
                end else begin
                    mask <= mask_set;
                end
            end
            // A fresh multi-anode condition wins over a simultaneous clear.
            if (an_multi) begin
                anode_err <= 1'b1;
            end else if (err_clr) begin
                anode_err <= 1'b0;
            end
        end
    end

    assign seg0   = seg_q[0];
    assign seg1   = seg_q[1];
    assign seg2   = seg_q[2];
    assign seg3   = seg_q[3];
    assign hex0   = hex_q[0];
    assign hex1   = hex_q[1];
    assign hex2   = hex_q[2];
    assign hex3   = hex_q[3];
    assign valid0 = valid_q[0];
    assign valid1 = valid_q[1];
    assign valid2 = valid_q[2];
    assign valid3 = valid_q[3];

endmodule

// File: tb/tb_seg_scan_capture.sv
// Directed bench for seg_scan_capture with default parameters (SETTLE=4, active-low segments).
module tb_seg_scan_capture;

    logic       clock;
    logic       reset;
    logic       A, B, C, D, E, F, G;
    logic       An0, An1, An2, An3;
    logic       err_clr;
    logic [6:0] seg0, seg1, seg2, seg3;
    logic [3:0] hex0, hex1, hex2, hex3;
    logic       valid0, valid1, valid2, valid3;
    logic       frame_done;
    logic       anode_err;

    int n_checks;
    int n_errors;

    logic [6:0] segv [4];
    logic [3:0] hexv [4];
    logic       vldv [4];

    logic [6:0] scan_pat [4];
    logic [3:0] scan_an  [4];
    logic [3:0] scan_hex [4];

    seg_scan_capture dut (
        .clock      (clock),
        .reset      (reset),
        .A          (A),
        .B          (B),
        .C          (C),
        .D          (D),
        .E          (E),
        .F          (F),
        .G          (G),
        .An0        (An0),
        .An1        (An1),
        .An2        (An2),
        .An3        (An3),
        .err_clr    (err_clr),
        .seg0       (seg0),
        .seg1       (seg1),
        .seg2       (seg2),
        .seg3       (seg3),
        .hex0       (hex0),
        .hex1       (hex1),
        .hex2       (hex2),
        .hex3       (hex3),
        .valid0     (valid0),
        .valid1     (valid1),
        .valid2     (valid2),
        .valid3     (valid3),
        .frame_done (frame_done),
        .anode_err  (anode_err)
    );

    assign segv[0] = seg0;
    assign segv[1] = seg1;
    assign segv[2] = seg2;
    assign segv[3] = seg3;
    assign hexv[0] = hex0;
    assign hexv[1] = hex1;
    assign hexv[2] = hex2;
    assign hexv[3] = hex3;
    assign vldv[0] = valid0;
    assign vldv[1] = valid1;
    assign vldv[2] = valid2;
    assign vldv[3] = valid3;

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Drives a logical pattern (bit6 = A, 1 = lit) and {An3..An0} on the falling edge.
    task automatic set_in(input logic [6:0] lseg, input logic [3:0] an);
        @(negedge clock);
        {A, B, C, D, E, F, G} = ~lseg;
        {An3, An2, An1, An0}  = an;
    endtask

    task automatic edges(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    task automatic chk_all_zero(input string tag);
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("%s_seg%0d", tag, i), 32'(segv[i]), 32'h0);
            chk($sformatf("%s_hex%0d", tag, i), 32'(hexv[i]), 32'h0);
            chk($sformatf("%s_vld%0d", tag, i), 32'(vldv[i]), 32'h0);
        end
        chk({tag, "_fd"}, 32'(frame_done), 32'h0);
        chk({tag, "_err"}, 32'(anode_err), 32'h0);
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        scan_pat[0] = 7'h30; scan_an[0] = 4'b1110; scan_hex[0] = 4'h1;
        scan_pat[1] = 7'h6D; scan_an[1] = 4'b1101; scan_hex[1] = 4'h2;
        scan_pat[2] = 7'h79; scan_an[2] = 4'b1011; scan_hex[2] = 4'h3;
        scan_pat[3] = 7'h33; scan_an[3] = 4'b0111; scan_hex[3] = 4'h4;

        // Reset asserted with arbitrary inputs, before any clock edge
        reset   = 1'b0;
        err_clr = 1'b1;
        {A, B, C, D, E, F, G} = 7'h55;
        {An3, An2, An1, An0}  = 4'b0000;
        #2;
        chk_all_zero("rst_async");
        edges(3);
        chk_all_zero("rst_held");
        err_clr = 1'b0;
        set_in(7'h00, 4'b1111);
        reset = 1'b1;
        edges(2);

        // Digit 1 enabled only two cycles: too short to capture
        set_in(7'h30, 4'b1101);
        edges(2);
        set_in(7'h30, 4'b1111);
        edges(6);
        chk("short_seg1", 32'(seg1), 32'h0);
        chk("short_hex1", 32'(hex1), 32'h0);
        chk("short_vld1", 32'(valid1), 32'h0);

        // Digit 0 showing '0': capture on the 5th edge, then stable
        set_in(7'h7E, 4'b1110);
        edges(4);
        chk("d0_pre_seg", 32'(seg0), 32'h0);
        chk("d0_pre_vld", 32'(valid0), 32'h0);
        edges(1);
        chk("d0_seg", 32'(seg0), 32'h7E);
        chk("d0_hex", 32'(hex0), 32'h0);
        chk("d0_vld", 32'(valid0), 32'h1);
        edges(5);
        chk("d0_hold_seg", 32'(seg0), 32'h7E);
        chk("d0_hold_vld", 32'(valid0), 32'h1);
        chk("d0_hold_fd", 32'(frame_done), 32'h0);

        // Unrecognised pattern (G only) on digit 2
        set_in(7'h01, 4'b1011);
        edges(5);
        chk("g_seg2", 32'(seg2), 32'h01);
        chk("g_hex2", 32'(hex2), 32'h0);
        chk("g_vld2", 32'(valid2), 32'h0);

        // Full scan 1,2,3,4; frame completes only on the digit-3 capture edge
        for (int d = 0; d < 4; d++) begin
            set_in(scan_pat[d], scan_an[d]);
            for (int c = 1; c <= 8; c++) begin
                edges(1);
                chk($sformatf("scan_fd_d%0d_c%0d", d, c), 32'(frame_done),
                    32'((d == 3 && c == 5) ? 1 : 0));
            end
        end
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("scan_seg%0d", i), 32'(segv[i]), 32'(scan_pat[i]));
            chk($sformatf("scan_hex%0d", i), 32'(hexv[i]), 32'(scan_hex[i]));
            chk($sformatf("scan_vld%0d", i), 32'(vldv[i]), 32'h1);
        end

        // Two anodes at once: sticky error, nothing captured
        set_in(7'h7F, 4'b1100);
        edges(6);
        chk("multi_err", 32'(anode_err), 32'h1);
        chk("multi_hex0", 32'(hex0), 32'h1);
        chk("multi_hex1", 32'(hex1), 32'h2);
        chk("multi_seg0", 32'(seg0), 32'h30);
        set_in(7'h7F, 4'b1111);
        edges(2);
        chk("multi_sticky", 32'(anode_err), 32'h1);
        @(negedge clock);
        err_clr = 1'b1;
        edges(1);
        chk("multi_clr", 32'(anode_err), 32'h0);
        @(negedge clock);
        err_clr = 1'b0;

        // Clear in the same cycle as a multi-anode condition leaves the flag set
        set_in(7'h7F, 4'b1100);
        edges(2);
        chk("race_set", 32'(anode_err), 32'h1);
        @(negedge clock);
        err_clr = 1'b1;
        edges(1);
        chk("race_keep", 32'(anode_err), 32'h1);
        set_in(7'h7F, 4'b1111);
        edges(1);
        chk("race_lag", 32'(anode_err), 32'h1);
        edges(1);
        chk("race_clr", 32'(anode_err), 32'h0);
        @(negedge clock);
        err_clr = 1'b0;

        // Reset during SETTLE discards the pending capture
        set_in(7'h5B, 4'b1101);
        edges(3);
        @(negedge clock);
        reset = 1'b0;
        #1;
        chk_all_zero("rst_mid");
        set_in(7'h5B, 4'b1111);
        reset = 1'b1;
        edges(8);
        chk("rst_mid_seg1", 32'(seg1), 32'h0);
        chk("rst_mid_vld1", 32'(valid1), 32'h0);

        // Segment change during SETTLE restarts the stability count
        set_in(7'h5F, 4'b1110);
        edges(3);
        set_in(7'h70, 4'b1110);
        edges(4);
        chk("restart_pre_seg0", 32'(seg0), 32'h0);
        edges(1);
        chk("restart_seg0", 32'(seg0), 32'h70);
        chk("restart_hex0", 32'(hex0), 32'h7);
        chk("restart_vld0", 32'(valid0), 32'h1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
